// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor: counter encoding, table entry
// layout and the saturating counter update rule.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Tag storage is sized for the smallest legal table (PC[31:2]); unused
    // upper bits stay zero and are pruned by synthesis.
    localparam int unsigned TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic ctr_t sat_update(ctr_t c, logic t);
        ctr_t n;
        n = c;
        if (t) begin
            if (c != CTR_ST) n = ctr_t'(c + 2'd1);
        end else begin
            if (c != CTR_SNT) n = ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Lookup and training bus between fetch/EX and the branch target predictor.
interface branch_target_predictor_if;

    logic [31:0] PC;
    logic        hit;
    logic        taken;
    logic [31:0] PC_Target;
    logic        ID_EX_Branch;
    logic [31:0] ID_EX_PC;
    logic [31:0] ID_EX_Target;
    logic        Pcsrc;
    logic        flush_all;

    modport master (
        output PC, ID_EX_Branch, ID_EX_PC, ID_EX_Target, Pcsrc, flush_all,
        input  hit, taken, PC_Target
    );

    modport slave (
        input  PC, ID_EX_Branch, ID_EX_PC, ID_EX_Target, Pcsrc, flush_all,
        output hit, taken, PC_Target
    );

endinterface

// File: rtl/branch_target_predictor_sat_counter2.sv
// Combinational next state of one 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_t c,
    input  logic t,
    output ctr_t n
);

    assign n = sat_update(c, t);

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational lookup and
// training from EX. Define BTP_WRITE_BYPASS_EN to forward same-cycle updates.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES     = 16,
    parameter ctr_t        CTR_INIT_T  = CTR_WT,
    parameter ctr_t        CTR_INIT_NT = CTR_WNT
) (
    input  logic                       clk,
    input  logic                       reset,
    branch_target_predictor_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    function automatic logic [TAG_MAX_W-1:0] tag_of(logic [31:0] pc);
        return pc[31:2] >> IDX_W;
    endfunction

    btb_entry_t btb_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    btb_entry_t       cur_entry;
    btb_entry_t       upd_entry;
    btb_entry_t       lk_entry;
    logic             up_hit;
    ctr_t             ctr_next;
    logic             unused_pc_lsb;

    assign lk_idx        = bus.PC[IDX_W+1:2];
    assign up_idx        = bus.ID_EX_PC[IDX_W+1:2];
    assign cur_entry     = btb_q[up_idx];
    assign up_hit        = cur_entry.valid && (cur_entry.tag == tag_of(bus.ID_EX_PC));
    assign unused_pc_lsb = ^bus.ID_EX_PC[1:0];

    sat_counter2 u_ctr (
        .c (cur_entry.ctr),
        .t (bus.Pcsrc),
        .n (ctr_next)
    );

    // Post-update contents of the entry addressed by the resolving branch
    always_comb begin
        upd_entry = cur_entry;
        if (up_hit) begin
            upd_entry.ctr = ctr_next;
            if (bus.Pcsrc) upd_entry.target = bus.ID_EX_Target;
        end else begin
            upd_entry.valid  = 1'b1;
            upd_entry.tag    = tag_of(bus.ID_EX_PC);
            upd_entry.target = bus.ID_EX_Target;
            upd_entry.ctr    = bus.Pcsrc ? CTR_INIT_T : CTR_INIT_NT;
        end
    end

`ifdef BTP_WRITE_BYPASS_EN
    // Forward the update being written this edge; a flush drops the update
    logic byp;
    assign byp = bus.ID_EX_Branch && !bus.flush_all && (up_idx == lk_idx)
                 && (tag_of(bus.ID_EX_PC) == tag_of(bus.PC));
    assign lk_entry = byp ? upd_entry : btb_q[lk_idx];
`else
    assign lk_entry = btb_q[lk_idx];
`endif

    always_comb begin
        bus.hit       = lk_entry.valid && (lk_entry.tag == tag_of(bus.PC));
        bus.taken     = bus.hit && lk_entry.ctr[1];
        bus.PC_Target = bus.taken ? lk_entry.target : bus.PC + PC_STEP;
    end

    // Table storage; flush beats a coincident update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (bus.flush_all) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb_q[i].valid <= 1'b0;
            end
        end else if (bus.ID_EX_Branch) begin
            btb_q[up_idx] <= upd_entry;
        end
    end

endmodule
